fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 13 +
 rtl/fifo_wr_arbiter_if.sv | 34 +++
 rtl/rr_picker.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 97 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and default constants for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_N_REQ = 4;
    localparam int DEF_BURST = 4;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester/FIFO-side signal bundle for the FIFO write arbiter
// Signals (named from the arbiter's point of view):
//   i_Req     requester "has word" flags, one per requester
//   i_Data    flattened requester words, slice k = [k*WIDTH +: WIDTH]
//   i_Full    FIFO full flag
//   o_Gnt     one-hot-or-zero grant vector
//   o_WR_En   FIFO write enable
//   o_WR_Data FIFO write data
//   o_Busy    high while a grant is active
// Modports: master = arbiter side, slave = requesters/FIFO side.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_REQ = DEF_N_REQ
);
    logic [N_REQ-1:0]       i_Req;
    logic [N_REQ*WIDTH-1:0] i_Data;
    logic                   i_Full;
    logic [N_REQ-1:0]       o_Gnt;
    logic                   o_WR_En;
    logic [WIDTH-1:0]       o_WR_Data;
    logic                   o_Busy;

    modport master (
        input  i_Req, i_Data, i_Full,
        output o_Gnt, o_WR_En, o_WR_Data, o_Busy
    );

    modport slave (
        output i_Req, i_Data, i_Full,
        input  o_Gnt, o_WR_En, o_WR_Data, o_Busy
    );
endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner selection
// Ports:
//   i_req   request vector
//   i_last  index of the previous winner; search starts at (i_last+1) mod N_REQ
//   o_idx   winning index (0 when no request)
//   o_valid high when any request is present
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);
    // One extra bit so last + offset (< 2*N_REQ) never overflows before the wrap.
    logic [IDX_W:0] w_cand;

    // Walk from the farthest candidate to the nearest so the nearest
    // requesting index (in round-robin order) is the last one written.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            w_cand = {1'b0, i_last} + (IDX_W+1)'(i);
            if (w_cand >= (IDX_W+1)'(N_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(N_REQ);
            end
            if (i_req[w_cand[IDX_W-1:0]]) begin
                o_idx   = w_cand[IDX_W-1:0];
                o_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, burst-limited arbiter feeding one FIFO write port
// Ports:
//   i_clk    FIFO write clock
//   i_rst_n  asynchronous active-low reset
//   bus      fifo_wr_arbiter_if.master (requests/data/full in; grant/write/busy out)
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_REQ = DEF_N_REQ,
    parameter int BURST = DEF_BURST
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    fifo_wr_arbiter_if.master bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(BURST + 1);

    arb_state_t       r_state;
    logic [N_REQ-1:0] r_gnt;
    logic [IDX_W-1:0] r_last;
    logic [CNT_W-1:0] r_cnt;

    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_valid;
    logic             w_gnt_req;
    logic             w_xfer;
    logic             w_cnt_last;
    logic             w_release;
    logic [WIDTH-1:0] w_wr_data;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req   (bus.i_Req),
        .i_last  (r_last),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Grant is one-hot, so the reduction picks out the granted requester's flag.
    assign w_gnt_req  = |(r_gnt & bus.i_Req);
    assign w_xfer     = (r_state == GRANT) && w_gnt_req && !bus.i_Full;
    assign w_cnt_last = (r_cnt == CNT_W'(BURST - 1));
    // A dropped request releases even while the FIFO is full.
    assign w_release  = !w_gnt_req || (w_xfer && w_cnt_last);

    always_comb begin
        w_wr_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_gnt[k]) begin
                w_wr_data = bus.i_Data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_last  <= IDX_W'(N_REQ - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_gnt   <= N_REQ'(1) << w_pick_idx;
                        r_last  <= w_pick_idx;
                        r_cnt   <= '0;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_xfer && (r_cnt != CNT_W'(BURST))) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    // Always pass through IDLE so every grant is followed by a gap.
                    if (w_release) begin
                        r_gnt   <= '0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_Gnt     = r_gnt;
    assign bus.o_WR_En   = w_xfer;
    assign bus.o_WR_Data = w_wr_data;
    assign bus.o_Busy    = (r_state == GRANT);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.WIDTH(8), .N_REQ(4)) bus4 ();
    fifo_wr_arbiter_if #(.WIDTH(8), .N_REQ(4)) bus1 ();

    fifo_wr_arbiter #(.WIDTH(8), .N_REQ(4), .BURST(4)) dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus4.master)
    );

    fifo_wr_arbiter #(.WIDTH(8), .N_REQ(4), .BURST(1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus1.master)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic sel1 = 1'b0;

    // Requester model: queued words per requester and the next index to present.
    int         nw  [4];
    int         idx [4];
    logic [7:0] words [4][16];

    logic [3:0] g_log  [$];
    logic       we_log [$];
    logic [7:0] d_log  [$];

    logic [3:0] obs_gnt;
    logic       obs_we;
    logic [7:0] obs_data;
    logic       obs_busy;

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            nw[k]  = 0;
            idx[k] = 0;
        end
        g_log.delete();
        we_log.delete();
        d_log.delete();
    endtask

    task automatic drive_inputs(input logic full);
        logic [3:0]  req;
        logic [31:0] data;
        req  = '0;
        data = '0;
        for (int k = 0; k < 4; k++) begin
            if (idx[k] < nw[k]) begin
                req[k]          = 1'b1;
                data[k*8 +: 8]  = words[k][idx[k]];
            end
        end
        bus4.i_Req = req; bus4.i_Data = data; bus4.i_Full = full;
        bus1.i_Req = req; bus1.i_Data = data; bus1.i_Full = full;
    endtask

    task automatic sample();
        #1;
        if (sel1) begin
            obs_gnt = bus1.o_Gnt; obs_we = bus1.o_WR_En;
            obs_data = bus1.o_WR_Data; obs_busy = bus1.o_Busy;
        end else begin
            obs_gnt = bus4.o_Gnt; obs_we = bus4.o_WR_En;
            obs_data = bus4.o_WR_Data; obs_busy = bus4.o_Busy;
        end
    endtask

    // One clock: drive at negedge, observe, then advance any requester whose word was accepted.
    task automatic step(input logic full);
        @(negedge clk);
        drive_inputs(full);
        sample();
        g_log.push_back(obs_gnt);
        we_log.push_back(obs_we);
        if (obs_we) d_log.push_back(obs_data);
        for (int k = 0; k < 4; k++) begin
            if (obs_gnt[k] && !full && idx[k] < nw[k]) idx[k]++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_model();
        drive_inputs(1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_model();
        for (int k = 0; k < 4; k++) begin
            nw[k] = 1;
            words[k][0] = 8'hFF;
        end
        drive_inputs(1'b0);
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (bus4.o_Gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt4: got %b expected 0000", bus4.o_Gnt); end
        n_checks++; if (bus4.o_WR_En !== 1'b0) begin n_fail++; $display("FAIL reset_we4: got %b expected 0", bus4.o_WR_En); end
        n_checks++; if (bus4.o_WR_Data !== 8'h00) begin n_fail++; $display("FAIL reset_data4: got %h expected 00", bus4.o_WR_Data); end
        n_checks++; if (bus4.o_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy4: got %b expected 0", bus4.o_Busy); end
        n_checks++; if (bus1.o_Gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt1: got %b expected 0000", bus1.o_Gnt); end
        n_checks++; if (bus1.o_WR_En !== 1'b0) begin n_fail++; $display("FAIL reset_we1: got %b expected 0", bus1.o_WR_En); end
        n_checks++; if (bus1.o_WR_Data !== 8'h00) begin n_fail++; $display("FAIL reset_data1: got %h expected 00", bus1.o_WR_Data); end
        n_checks++; if (bus1.o_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy1: got %b expected 0", bus1.o_Busy); end
    endtask

    task automatic test_single();
        logic [3:0] exp_g  [4] = '{4'h0, 4'h1, 4'h1, 4'h0};
        logic       exp_we [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        sel1 = 1'b0;
        nw[0] = 1; words[0][0] = 8'hAB;
        repeat (4) step(1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (g_log[i] !== exp_g[i]) begin n_fail++; $display("FAIL single_gnt[%0d]: got %b expected %b", i, g_log[i], exp_g[i]); end
            n_checks++; if (we_log[i] !== exp_we[i]) begin n_fail++; $display("FAIL single_we[%0d]: got %b expected %b", i, we_log[i], exp_we[i]); end
        end
        n_checks++;
        if (d_log.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", d_log.size()); end
        else if (d_log[0] !== 8'hAB) begin n_fail++; $display("FAIL single_data: got %h expected ab", d_log[0]); end
    endtask

    task automatic test_burst_limit();
        logic [3:0] exp_g  [11] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
        logic       exp_we [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        do_reset();
        sel1 = 1'b0;
        nw[2] = 8;
        for (int j = 0; j < 8; j++) words[2][j] = 8'h40 + 8'(j);
        repeat (11) step(1'b0);
        for (int i = 0; i < 11; i++) begin
            n_checks++; if (g_log[i] !== exp_g[i]) begin n_fail++; $display("FAIL burst_gnt[%0d]: got %b expected %b", i, g_log[i], exp_g[i]); end
            n_checks++; if (we_log[i] !== exp_we[i]) begin n_fail++; $display("FAIL burst_we[%0d]: got %b expected %b", i, we_log[i], exp_we[i]); end
        end
        n_checks++;
        if (d_log.size() != 8) begin n_fail++; $display("FAIL burst_count: got %0d expected 8", d_log.size()); end
        for (int i = 0; i < 8 && i < d_log.size(); i++) begin
            n_checks++; if (d_log[i] !== 8'h40 + 8'(i)) begin n_fail++; $display("FAIL burst_data[%0d]: got %h expected %h", i, d_log[i], 8'h40 + 8'(i)); end
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g [17] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0,
                                   4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0};
        logic [7:0] exp_d [8]  = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31};
        do_reset();
        sel1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            nw[k] = 2;
            for (int j = 0; j < 2; j++) words[k][j] = {4'(k), 4'(j)};
        end
        repeat (17) step(1'b0);
        for (int i = 0; i < 17; i++) begin
            n_checks++; if (g_log[i] !== exp_g[i]) begin n_fail++; $display("FAIL fair_gnt[%0d]: got %b expected %b", i, g_log[i], exp_g[i]); end
            n_checks++; if (we_log[i] !== 1'(i % 2)) begin n_fail++; $display("FAIL fair_we[%0d]: got %b expected %b", i, we_log[i], 1'(i % 2)); end
        end
        n_checks++;
        if (d_log.size() != 8) begin n_fail++; $display("FAIL fair_count: got %0d expected 8", d_log.size()); end
        for (int i = 0; i < 8 && i < d_log.size(); i++) begin
            n_checks++; if (d_log[i] !== exp_d[i]) begin n_fail++; $display("FAIL fair_data[%0d]: got %h expected %h", i, d_log[i], exp_d[i]); end
        end
        sel1 = 1'b0;
    endtask

    task automatic test_full_stall();
        logic       full_s [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] exp_g  [9] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0};
        logic       exp_we [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        sel1 = 1'b0;
        nw[1] = 4;
        for (int j = 0; j < 4; j++) words[1][j] = 8'h50 + 8'(j);
        for (int i = 0; i < 9; i++) begin
            step(full_s[i]);
            if (i == 4) begin
                n_checks++; if (obs_busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy: got %b expected 1", obs_busy); end
            end
        end
        for (int i = 0; i < 9; i++) begin
            n_checks++; if (g_log[i] !== exp_g[i]) begin n_fail++; $display("FAIL stall_gnt[%0d]: got %b expected %b", i, g_log[i], exp_g[i]); end
            n_checks++; if (we_log[i] !== exp_we[i]) begin n_fail++; $display("FAIL stall_we[%0d]: got %b expected %b", i, we_log[i], exp_we[i]); end
        end
        n_checks++;
        if (d_log.size() != 4) begin n_fail++; $display("FAIL stall_count: got %0d expected 4", d_log.size()); end
        for (int i = 0; i < 4 && i < d_log.size(); i++) begin
            n_checks++; if (d_log[i] !== 8'h50 + 8'(i)) begin n_fail++; $display("FAIL stall_data[%0d]: got %h expected %h", i, d_log[i], 8'h50 + 8'(i)); end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0] exp_g  [4] = '{4'h1, 4'h1, 4'h0, 4'h4};
        logic       exp_we [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [7:0] exp_d  [2] = '{8'h70, 8'h62};
        do_reset();
        sel1 = 1'b0;
        nw[2] = 6;
        for (int j = 0; j < 6; j++) words[2][j] = 8'h60 + 8'(j);
        repeat (3) step(1'b0);
        @(negedge clk);
        nw[0] = 1; words[0][0] = 8'h70;
        drive_inputs(1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus4.o_Gnt !== 4'b0000) begin n_fail++; $display("FAIL rstmid_gnt: got %b expected 0000", bus4.o_Gnt); end
        n_checks++; if (bus4.o_WR_En !== 1'b0) begin n_fail++; $display("FAIL rstmid_we: got %b expected 0", bus4.o_WR_En); end
        n_checks++; if (bus4.o_Busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bus4.o_Busy); end
        @(negedge clk);
        rst_n = 1'b1;
        g_log.delete(); we_log.delete(); d_log.delete();
        repeat (4) step(1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (g_log[i] !== exp_g[i]) begin n_fail++; $display("FAIL rstmid_after_gnt[%0d]: got %b expected %b", i, g_log[i], exp_g[i]); end
            n_checks++; if (we_log[i] !== exp_we[i]) begin n_fail++; $display("FAIL rstmid_after_we[%0d]: got %b expected %b", i, we_log[i], exp_we[i]); end
        end
        n_checks++;
        if (d_log.size() != 2) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 2", d_log.size()); end
        for (int i = 0; i < 2 && i < d_log.size(); i++) begin
            n_checks++; if (d_log[i] !== exp_d[i]) begin n_fail++; $display("FAIL rstmid_data[%0d]: got %h expected %h", i, d_log[i], exp_d[i]); end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_g  [7] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h8, 4'h8, 4'h0};
        logic       exp_we [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] exp_d  [2] = '{8'h80, 8'h83};
        do_reset();
        sel1 = 1'b0;
        nw[0] = 1; words[0][0] = 8'h80;
        nw[3] = 1; words[3][0] = 8'h83;
        repeat (7) step(1'b0);
        for (int i = 0; i < 7; i++) begin
            n_checks++; if (g_log[i] !== exp_g[i]) begin n_fail++; $display("FAIL wrap_gnt[%0d]: got %b expected %b", i, g_log[i], exp_g[i]); end
            n_checks++; if (we_log[i] !== exp_we[i]) begin n_fail++; $display("FAIL wrap_we[%0d]: got %b expected %b", i, we_log[i], exp_we[i]); end
        end
        n_checks++;
        if (d_log.size() != 2) begin n_fail++; $display("FAIL wrap_count: got %0d expected 2", d_log.size()); end
        for (int i = 0; i < 2 && i < d_log.size(); i++) begin
            n_checks++; if (d_log[i] !== exp_d[i]) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, d_log[i], exp_d[i]); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_burst_limit();
        test_fairness();
        test_full_stall();
        test_reset_mid_burst();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
